// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised register file with forwarding and busy scoreboard
// Optional REG0_ZERO_EN: register 0 reads as zero, ignores writes and reservations.
module register_file_sb #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = ($clog2(NREGS) > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic              ren_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rbusy_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              ren_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rbusy_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              all_clear
);

`ifdef REG0_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic              rbusy_a_q, rbusy_a_d, rbusy_b_q, rbusy_b_d;

  // Addresses outside FIRST..NREGS-1 never match a loop index, so they are
  // ignored for writes/reserves and read back as zero / not busy.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    rdata_a_d = rdata_a_q;
    rbusy_a_d = rbusy_a_q;
    rdata_b_d = rdata_b_q;
    rbusy_b_d = rbusy_b_q;

    for (int i = FIRST; i < NREGS; i++) begin
      if (we && waddr == ADDR_W'(i)) begin
        regs_d[i] = wdata;
        busy_d[i] = 1'b0;
      end
      if (rsv_en && rsv_addr == ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
      end
    end

    if (ren_a) begin
      rdata_a_d = '0;
      rbusy_a_d = 1'b0;
      for (int i = FIRST; i < NREGS; i++) begin
        if (raddr_a == ADDR_W'(i)) begin
          rdata_a_d = (we && waddr == raddr_a) ? wdata : regs_q[i];
          rbusy_a_d = busy_d[i];
        end
      end
    end

    if (ren_b) begin
      rdata_b_d = '0;
      rbusy_b_d = 1'b0;
      for (int i = FIRST; i < NREGS; i++) begin
        if (raddr_b == ADDR_W'(i)) begin
          rdata_b_d = (we && waddr == raddr_b) ? wdata : regs_q[i];
          rbusy_b_d = busy_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      rdata_a_q <= '0;
      rbusy_a_q <= 1'b0;
      rdata_b_q <= '0;
      rbusy_b_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q    <= busy_d;
      rdata_a_q <= rdata_a_d;
      rbusy_a_q <= rbusy_a_d;
      rdata_b_q <= rdata_b_d;
      rbusy_b_q <= rbusy_b_d;
    end
  end

  assign rdata_a   = rdata_a_q;
  assign rbusy_a   = rbusy_a_q;
  assign rdata_b   = rdata_b_q;
  assign rbusy_b   = rbusy_b_q;
  assign all_clear = ~|busy_q;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - directed bench for register_file_sb (NREGS=5, ADDR_W=3)
module tb_register_file_sb;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] raddr_a, raddr_b, waddr, rsv_addr;
  logic       ren_a, ren_b, we, rsv_en;
  logic [7:0] wdata;
  logic [7:0] rdata_a, rdata_b;
  logic       rbusy_a, rbusy_b, all_clear;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  register_file_sb #(.DATA_W(8), .NREGS(5), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .raddr_a(raddr_a), .ren_a(ren_a), .rdata_a(rdata_a), .rbusy_a(rbusy_a),
    .raddr_b(raddr_b), .ren_b(ren_b), .rdata_b(rdata_b), .rbusy_b(rbusy_b),
    .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .all_clear(all_clear)
  );

  task automatic idle();
    reset = 1'b0; ren_a = 1'b0; ren_b = 1'b0; we = 1'b0; rsv_en = 1'b0;
    raddr_a = '0; raddr_b = '0; waddr = '0; rsv_addr = '0; wdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 8'hEE; ren_a = 1'b1;
    cyc();
    checks++;
    if (rdata_a !== 8'h00 || rbusy_a !== 1'b0 || all_clear !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: rdata_a=%h rbusy_a=%b all_clear=%b, expected 00 0 1", rdata_a, rbusy_a, all_clear);
    end
    idle();
    ren_a = 1'b1; raddr_a = 3'd0; ren_b = 1'b1; raddr_b = 3'd3;
    cyc();
    checks++;
    if (rdata_a !== 8'h00 || rdata_b !== 8'h00 || rbusy_a !== 1'b0 || rbusy_b !== 1'b0 || all_clear !== 1'b1) begin
      failures++;
      $display("FAIL reset_read: a=%h/%b b=%h/%b clr=%b, expected 00/0 00/0 1", rdata_a, rbusy_a, rdata_b, rbusy_b, all_clear);
    end
  endtask

  task automatic test_write_read();
    idle();
    we = 1'b1; waddr = 3'd2; wdata = 8'hA5;
    cyc();
    idle();
    ren_a = 1'b1; raddr_a = 3'd2;
    cyc();
    checks++;
    if (rdata_a !== 8'hA5) begin
      failures++;
      $display("FAIL write_read: rdata_a=%h, expected a5", rdata_a);
    end
    idle();
    we = 1'b1; waddr = 3'd2; wdata = 8'h11;
    cyc();
    checks++;
    if (rdata_a !== 8'hA5) begin
      failures++;
      $display("FAIL read_hold: rdata_a=%h, expected a5", rdata_a);
    end
  endtask

  task automatic test_forward();
    idle();
    we = 1'b1; waddr = 3'd1; wdata = 8'h3C; ren_a = 1'b1; raddr_a = 3'd1;
    cyc();
    checks++;
    if (rdata_a !== 8'h3C) begin
      failures++;
      $display("FAIL forward: rdata_a=%h, expected 3c", rdata_a);
    end
    idle();
    ren_b = 1'b1; raddr_b = 3'd1;
    cyc();
    checks++;
    if (rdata_b !== 8'h3C) begin
      failures++;
      $display("FAIL forward_stored: rdata_b=%h, expected 3c", rdata_b);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd3;
    cyc();
    checks++;
    if (all_clear !== 1'b0) begin
      failures++;
      $display("FAIL rsv_clear: all_clear=%b, expected 0", all_clear);
    end
    idle();
    ren_a = 1'b1; raddr_a = 3'd3;
    cyc();
    checks++;
    if (rbusy_a !== 1'b1) begin
      failures++;
      $display("FAIL rsv_busy: rbusy_a=%b, expected 1", rbusy_a);
    end
    idle();
    we = 1'b1; waddr = 3'd3; wdata = 8'h77;
    cyc();
    checks++;
    if (all_clear !== 1'b1) begin
      failures++;
      $display("FAIL wr_clears: all_clear=%b, expected 1", all_clear);
    end
    idle();
    ren_a = 1'b1; raddr_a = 3'd3;
    cyc();
    checks++;
    if (rdata_a !== 8'h77 || rbusy_a !== 1'b0) begin
      failures++;
      $display("FAIL wr_read: rdata_a=%h rbusy_a=%b, expected 77 0", rdata_a, rbusy_a);
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd4; ren_b = 1'b1; raddr_b = 3'd4;
    cyc();
    checks++;
    if (rbusy_b !== 1'b1 || rdata_b !== 8'h00) begin
      failures++;
      $display("FAIL rsv_same_cycle_read: rbusy_b=%b rdata_b=%h, expected 1 00", rbusy_b, rdata_b);
    end
    idle();
    we = 1'b1; waddr = 3'd3; wdata = 8'h99; rsv_en = 1'b1; rsv_addr = 3'd3;
    ren_a = 1'b1; raddr_a = 3'd3;
    cyc();
    checks++;
    if (rdata_a !== 8'h99 || rbusy_a !== 1'b1 || all_clear !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsv_same: rdata_a=%h rbusy_a=%b clr=%b, expected 99 1 0", rdata_a, rbusy_a, all_clear);
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd3;
    cyc();
    idle();
    ren_a = 1'b1; raddr_a = 3'd3;
    cyc();
    checks++;
    if (rbusy_a !== 1'b1) begin
      failures++;
      $display("FAIL rsv_again: rbusy_a=%b, expected 1", rbusy_a);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp_r [5];
    exp_r[0] = 8'h00; exp_r[1] = 8'h3C; exp_r[2] = 8'h11; exp_r[3] = 8'h99; exp_r[4] = 8'h00;
    idle();
    we = 1'b1; waddr = 3'd6; wdata = 8'hFF;
    cyc();
    idle();
    ren_a = 1'b1; raddr_a = 3'd6;
    cyc();
    checks++;
    if (rdata_a !== 8'h00 || rbusy_a !== 1'b0) begin
      failures++;
      $display("FAIL oor_read: rdata_a=%h rbusy_a=%b, expected 00 0", rdata_a, rbusy_a);
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      ren_b = 1'b1; raddr_b = 3'(i);
      cyc();
      checks++;
      if (rdata_b !== exp_r[i]) begin
        failures++;
        $display("FAIL oor_regs r%0d: rdata_b=%h, expected %h", i, rdata_b, exp_r[i]);
      end
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd7; ren_a = 1'b1; raddr_a = 3'd7;
    cyc();
    checks++;
    if (rbusy_a !== 1'b0) begin
      failures++;
      $display("FAIL oor_rsv: rbusy_a=%b, expected 0", rbusy_a);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    reset = 1'b1; rsv_en = 1'b1; rsv_addr = 3'd2; we = 1'b1; waddr = 3'd1; wdata = 8'h55;
    cyc();
    checks++;
    if (all_clear !== 1'b1 || rbusy_a !== 1'b0 || rdata_b !== 8'h00) begin
      failures++;
      $display("FAIL reset_stall: clr=%b rbusy_a=%b rdata_b=%h, expected 1 0 00", all_clear, rbusy_a, rdata_b);
    end
    idle();
    ren_a = 1'b1; raddr_a = 3'd3; ren_b = 1'b1; raddr_b = 3'd1;
    cyc();
    checks++;
    if (rbusy_a !== 1'b0 || rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
      failures++;
      $display("FAIL reset_stall_read: rbusy_a=%b a=%h b=%h, expected 0 00 00", rbusy_a, rdata_a, rdata_b);
    end
  endtask

  task automatic test_reg0();
    logic [7:0] exp_d;
    logic       exp_clr;
`ifdef REG0_ZERO_EN
    exp_d = 8'h00; exp_clr = 1'b1;
`else
    exp_d = 8'h12; exp_clr = 1'b0;
`endif
    idle();
    we = 1'b1; waddr = 3'd0; wdata = 8'h12; ren_a = 1'b1; raddr_a = 3'd0;
    cyc();
    checks++;
    if (rdata_a !== exp_d) begin
      failures++;
      $display("FAIL reg0_fwd: rdata_a=%h, expected %h", rdata_a, exp_d);
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd0; ren_b = 1'b1; raddr_b = 3'd0;
    cyc();
    checks++;
    if (all_clear !== exp_clr || rdata_b !== exp_d || rbusy_b !== ~exp_clr) begin
      failures++;
      $display("FAIL reg0_rsv: clr=%b rdata_b=%h rbusy_b=%b, expected %b %h %b", all_clear, rdata_b, rbusy_b, exp_clr, exp_d, ~exp_clr);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    test_reset();
    test_write_read();
    test_forward();
    test_scoreboard();
    test_out_of_range();
    test_reset_mid_stall();
    test_reg0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
